// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the IF/MEM SRAM arbiter.
// Optional build macro ARB_RR_EN (see sram_arbiter.sv) selects round-robin grant.
package sram_arbiter_pkg;

  localparam logic RST_ENABLE   = 1'b1;  // asserted level of rst
  localparam logic STALL_YES    = 1'b1;
  localparam logic STALL_NO     = 1'b0;
  localparam logic WRITE_ENABLE = 1'b1;  // mem_we level meaning "write"

  localparam int SRAM_DW = 16;  // SRAM data width
  localparam int CPU_AW  = 16;  // pipeline word-address width
  localparam int CNT_W   = 4;   // wait counter width (WAIT_CYCLES <= 15)

  typedef enum logic [2:0] {
    ARB_IDLE     = 3'd0,
    ARB_READ     = 3'd1,
    ARB_WR_SETUP = 3'd2,
    ARB_WR_PULSE = 3'd3,
    ARB_WR_HOLD  = 3'd4,
    ARB_DONE     = 3'd5
  } arb_state_e;

  typedef enum logic {
    ARB_PORT_IF  = 1'b0,
    ARB_PORT_MEM = 1'b1
  } arb_port_e;

  // Request as seen by the grant logic in IDLE
  typedef struct packed {
    arb_port_e           port;
    logic                we;
    logic [CPU_AW-1:0]   addr;
    logic [SRAM_DW-1:0]  wdata;
  } arb_req_t;

  // Pick the winning port. A lone request always wins; on a tie MEM wins
  // unless round-robin is on and MEM was the port served last.
  function automatic arb_port_e arb_pick(input logic if_req, input logic mem_req,
                                         input logic rr_en, input arb_port_e last);
    arb_port_e g;
    if (if_req && mem_req) begin
      if (rr_en && (last == ARB_PORT_MEM)) g = ARB_PORT_IF;
      else                                 g = ARB_PORT_MEM;
    end else if (mem_req) begin
      g = ARB_PORT_MEM;
    end else begin
      g = ARB_PORT_IF;
    end
    return g;
  endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Pipeline-side (IF, MEM) and SRAM-pin bundle for the SRAM arbiter.
// slave = arbiter view, master = pipeline/board view.
interface sram_arbiter_if
  import sram_arbiter_pkg::*;
#(
  parameter int SRAM_AW = 18
);
  // instruction fetch port (read only)
  logic               if_req;
  logic [CPU_AW-1:0]  if_addr;
  logic [SRAM_DW-1:0] if_rdata;
  logic               if_ready;
  logic               if_stall_o;
  // data memory port
  logic               mem_req;
  logic               mem_we;
  logic [CPU_AW-1:0]  mem_addr;
  logic [SRAM_DW-1:0] mem_wdata;
  logic [SRAM_DW-1:0] mem_rdata;
  logic               mem_ready;
  logic               mem_stall_o;
  // SRAM pins
  logic [SRAM_AW-1:0] sram_addr;
  logic [SRAM_DW-1:0] sram_dout;
  logic               sram_doe;
  logic [SRAM_DW-1:0] sram_din;
  logic               sram_ce_n;
  logic               sram_oe_n;
  logic               sram_we_n;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, sram_din,
    output if_rdata, if_ready, if_stall_o, mem_rdata, mem_ready, mem_stall_o,
    output sram_addr, sram_dout, sram_doe, sram_ce_n, sram_oe_n, sram_we_n
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, sram_din,
    input  if_rdata, if_ready, if_stall_o, mem_rdata, mem_ready, mem_stall_o,
    input  sram_addr, sram_dout, sram_doe, sram_ce_n, sram_oe_n, sram_we_n
  );
endinterface

// File: rtl/sram_arbiter.sv
// Shares one asynchronous SRAM between instruction fetch and the MEM stage.
// Sequences read (READ x WAIT_CYCLES) and write (SETUP, PULSE x WAIT_CYCLES,
// HOLD) timing, returns a one-cycle ready to the granted port and raises
// per-port stalls. Build macro ARB_RR_EN: round-robin grant on ties
// (default: fixed MEM priority). WAIT_CYCLES legal range 1..15.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int SRAM_AW     = 18
) (
  input  logic          clk,
  input  logic          rst,
  sram_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  arb_state_e         state_q;
  logic [CNT_W-1:0]   cnt_q;
  arb_port_e          port_q;
  arb_port_e          grant_d;
  arb_req_t           req_d;
  logic [SRAM_AW-1:0] addr_q;
  logic [SRAM_DW-1:0] dout_q;
  logic [SRAM_DW-1:0] if_rdata_q;
  logic [SRAM_DW-1:0] mem_rdata_q;
  logic               doe_q;
  logic               ce_n_q;
  logic               oe_n_q;
  logic               we_n_q;
  logic               if_ready_q;
  logic               mem_ready_q;

`ifdef ARB_RR_EN
  arb_port_e last_grant_q;
  assign grant_d = arb_pick(bus.if_req, bus.mem_req, 1'b1, last_grant_q);
`else
  assign grant_d = arb_pick(bus.if_req, bus.mem_req, 1'b0, ARB_PORT_IF);
`endif

  // Build the request that would be latched this cycle; IF is always a read
  always_comb begin
    req_d       = '0;
    req_d.port  = grant_d;
    req_d.we    = (grant_d == ARB_PORT_MEM) && (bus.mem_we == WRITE_ENABLE);
    req_d.addr  = (grant_d == ARB_PORT_MEM) ? bus.mem_addr : bus.if_addr;
    req_d.wdata = bus.mem_wdata;
  end

  // Access sequencer: grant, SRAM strobes, wait counter, rdata capture, ready
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q     <= ARB_IDLE;
      cnt_q       <= '0;
      port_q      <= ARB_PORT_IF;
      addr_q      <= '0;
      dout_q      <= '0;
      doe_q       <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
`ifdef ARB_RR_EN
      last_grant_q <= ARB_PORT_IF;
`endif
    end else begin
      // ready is a pulse: only the transition into DONE sets it
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          if (bus.if_req || bus.mem_req) begin
            port_q <= req_d.port;
            addr_q <= SRAM_AW'(req_d.addr);
            dout_q <= req_d.wdata;
            ce_n_q <= 1'b0;
`ifdef ARB_RR_EN
            last_grant_q <= req_d.port;
`endif
            if (req_d.we) begin
              doe_q   <= 1'b1;
              state_q <= ARB_WR_SETUP;
            end else begin
              oe_n_q  <= 1'b0;
              cnt_q   <= CNT_LOAD;
              state_q <= ARB_READ;
            end
          end
        end
        ARB_READ: begin
          if (cnt_q == '0) begin
            if (port_q == ARB_PORT_MEM) begin
              mem_rdata_q <= bus.sram_din;
              mem_ready_q <= 1'b1;
            end else begin
              if_rdata_q <= bus.sram_din;
              if_ready_q <= 1'b1;
            end
            oe_n_q  <= 1'b1;
            ce_n_q  <= 1'b1;
            state_q <= ARB_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ARB_WR_SETUP: begin
          we_n_q  <= 1'b0;
          cnt_q   <= CNT_LOAD;
          state_q <= ARB_WR_PULSE;
        end
        ARB_WR_PULSE: begin
          if (cnt_q == '0) begin
            we_n_q  <= 1'b1;
            state_q <= ARB_WR_HOLD;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ARB_WR_HOLD: begin
          // only MEM can write
          doe_q       <= 1'b0;
          ce_n_q      <= 1'b1;
          mem_ready_q <= 1'b1;
          state_q     <= ARB_DONE;
        end
        ARB_DONE: begin
          // requests ignored here: one idle cycle of bus turnaround
          state_q <= ARB_IDLE;
        end
        default: begin
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  assign bus.if_rdata    = if_rdata_q;
  assign bus.if_ready    = if_ready_q;
  assign bus.if_stall_o  = (bus.if_req & ~if_ready_q) ? STALL_YES : STALL_NO;
  assign bus.mem_rdata   = mem_rdata_q;
  assign bus.mem_ready   = mem_ready_q;
  assign bus.mem_stall_o = (bus.mem_req & ~mem_ready_q) ? STALL_YES : STALL_NO;
  assign bus.sram_addr   = addr_q;
  assign bus.sram_dout   = dout_q;
  assign bus.sram_doe    = doe_q;
  assign bus.sram_ce_n   = ce_n_q;
  assign bus.sram_oe_n   = oe_n_q;
  assign bus.sram_we_n   = we_n_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: directed timing cases plus randomized
// concurrent IF/MEM traffic against a word-array reference model.
module tb_sram_arbiter;
  localparam int W  = 2;
  localparam int AW = 18;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_arbiter_if #(.SRAM_AW(AW)) bus ();
  sram_arbiter #(.WAIT_CYCLES(W), .SRAM_AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed { logic we; logic [15:0] rdata; } exp_t;
  exp_t if_q[$];
  exp_t mem_q[$];
  exp_t e_if, e_mem;

  // reference model: IF region 0x0000-0x00FF, MEM region 0x8000-0x80FF
  logic [15:0] ref_mem [0:511];
  logic [15:0] mem_last = 16'h0;  // last value a MEM read returned

  // SRAM device attached to the pins
  logic [15:0] dev_dat [0:511];
  bit          dev_wr  [0:511];
  logic        din_ovr = 1'b0;
  logic [15:0] din_val = 16'h0;

  function automatic int idx(input logic [15:0] a);
    return int'({a[15], a[7:0]});
  endfunction
  function automatic logic [15:0] init_val(input int i);
    return 16'(i * 59) ^ 16'h5A5A;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk)
    if (!bus.sram_ce_n && !bus.sram_we_n && bus.sram_doe) begin
      dev_dat[idx(bus.sram_addr[15:0])] <= bus.sram_dout;
      dev_wr[idx(bus.sram_addr[15:0])]  <= 1'b1;
    end

  always @(negedge clk) begin
    if (din_ovr) bus.sram_din <= din_val;
    else if (!bus.sram_ce_n && !bus.sram_oe_n)
      bus.sram_din <= dev_wr[idx(bus.sram_addr[15:0])] ? dev_dat[idx(bus.sram_addr[15:0])]
                                                       : init_val(idx(bus.sram_addr[15:0]));
    else bus.sram_din <= 16'($urandom);
  end

  // monitor: pop expectations whenever a ready pulse is presented
  always @(negedge clk) begin
    if (bus.if_req) chk("if_stall", bus.if_stall_o, !bus.if_ready);
    if (bus.mem_req) chk("mem_stall", bus.mem_stall_o, !bus.mem_ready);
    if (bus.if_ready) begin
      chk("if_ready_expected", int'(if_q.size() != 0), 1);
      if (if_q.size() != 0) begin
        e_if = if_q.pop_front();
        chk("if_rdata", bus.if_rdata, e_if.rdata);
      end
    end
    if (bus.mem_ready) begin
      chk("mem_ready_expected", int'(mem_q.size() != 0), 1);
      if (mem_q.size() != 0) begin
        e_mem = mem_q.pop_front();
        chk(e_mem.we ? "mem_rdata_after_wr" : "mem_rdata", bus.mem_rdata, e_mem.rdata);
      end
    end
    if (bus.if_ready && bus.mem_ready) chk("single_ready", 2, 1);
  end

  task automatic issue_if(input logic [15:0] a, input logic [15:0] exp);
    if_q.push_back('{we: 1'b0, rdata: exp});
    bus.if_addr = a;
    bus.if_req  = 1'b1;
  endtask

  task automatic issue_mem(input logic we, input logic [15:0] a, input logic [15:0] wd);
    logic [15:0] e;
    if (we) begin
      ref_mem[idx(a)] = wd;
      e = mem_last;
    end else begin
      e = ref_mem[idx(a)];
      mem_last = e;
    end
    mem_q.push_back('{we: we, rdata: e});
    bus.mem_we    = we;
    bus.mem_addr  = a;
    bus.mem_wdata = wd;
    bus.mem_req   = 1'b1;
  endtask

  // watch one access issued at cycle t0: latency, address and strobe timing
  task automatic check_window(input string tag, input bit is_mem, input logic we,
                              input logic [15:0] a, input int t0);
    int lat = -1, oe_lo = 0, we_lo = 0, doe_hi = 0, first_we = -1, stall_hi = 0;
    logic [AW-1:0] a1 = '1;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      @(negedge clk);
      if (cyc - t0 == 1) a1 = bus.sram_addr;
      if (!bus.sram_oe_n) oe_lo++;
      if (!bus.sram_we_n) begin
        we_lo++;
        if (first_we < 0) first_we = cyc - t0;
      end
      if (bus.sram_doe) doe_hi++;
      if (is_mem ? bus.mem_stall_o : bus.if_stall_o) stall_hi++;
      if (is_mem ? bus.mem_ready : bus.if_ready) lat = cyc - t0;
    end
    if (is_mem) bus.mem_req = 1'b0;
    else        bus.if_req  = 1'b0;
    chk({tag, "_latency"}, lat, we ? W + 3 : W + 1);
    chk({tag, "_sram_addr"}, int'(a1), int'({2'b00, a}));
    chk({tag, "_oe_low_cycles"}, oe_lo, we ? 0 : W);
    chk({tag, "_we_low_cycles"}, we_lo, we ? W : 0);
    chk({tag, "_doe_cycles"}, doe_hi, we ? W + 2 : 0);
    if (we) chk({tag, "_we_first_cycle"}, first_we, 2);
    chk({tag, "_stall_cycles"}, stall_hi, we ? W + 2 : W);
  endtask

  task automatic wait_ready(input bit is_mem, input int bound, output int lat);
    int t0 = cyc;
    lat = -1;
    for (int i = 0; i < bound && lat < 0; i++) begin
      @(negedge clk);
      if (is_mem ? bus.mem_ready : bus.if_ready) lat = cyc - t0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, lat, if_lat, mem_lat, exp_if, exp_mem;
    int rdy [3];
    for (int i = 0; i < 512; i++) ref_mem[i] = init_val(i);
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0;

    // reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ce_n", bus.sram_ce_n, 1);
    chk("rst_oe_n", bus.sram_oe_n, 1);
    chk("rst_we_n", bus.sram_we_n, 1);
    chk("rst_doe", bus.sram_doe, 0);
    chk("rst_addr", int'(bus.sram_addr), 0);
    chk("rst_dout", bus.sram_dout, 0);
    chk("rst_if_rdata", bus.if_rdata, 0);
    chk("rst_mem_rdata", bus.mem_rdata, 0);
    chk("rst_if_ready", bus.if_ready, 0);
    chk("rst_mem_ready", bus.mem_ready, 0);
    rst = 1'b0;
    @(negedge clk);

    // IF read with fixed SRAM data
    din_ovr = 1'b1; din_val = 16'h1234;
    issue_if(16'h0040, 16'h1234); t0 = cyc;
    check_window("if_rd", 1'b0, 1'b0, 16'h0040, t0);
    din_ovr = 1'b0;
    repeat (2) @(negedge clk);

    // MEM write, then read it back
    issue_mem(1'b1, 16'h8000, 16'hBEEF); t0 = cyc;
    check_window("mem_wr", 1'b1, 1'b1, 16'h8000, t0);
    chk("sram_written", dev_dat[idx(16'h8000)], 16'hBEEF);
    repeat (2) @(negedge clk);
    issue_mem(1'b0, 16'h8000, 16'h0); t0 = cyc;
    check_window("mem_rd", 1'b1, 1'b0, 16'h8000, t0);
    repeat (2) @(negedge clk);

    // simultaneous requests; last served port was MEM
    issue_mem(1'b0, 16'h0010, 16'h0);
    issue_if(16'h0020, ref_mem[idx(16'h0020)]);
    t0 = cyc; if_lat = -1; mem_lat = -1;
    for (int i = 0; i < 40 && (if_lat < 0 || mem_lat < 0); i++) begin
      @(negedge clk);
      if (bus.mem_ready && mem_lat < 0) begin mem_lat = cyc - t0; bus.mem_req = 1'b0; end
      if (bus.if_ready && if_lat < 0) begin if_lat = cyc - t0; bus.if_req = 1'b0; end
    end
`ifdef ARB_RR_EN
    exp_if = W + 1; exp_mem = 2 * W + 3;
`else
    exp_mem = W + 1; exp_if = 2 * W + 3;
`endif
    chk("tie_mem_latency", mem_lat, exp_mem);
    chk("tie_if_latency", if_lat, exp_if);
    bus.if_req = 1'b0; bus.mem_req = 1'b0;
    repeat (2) @(negedge clk);

    // reset in the middle of the write pulse, request held through it
    issue_mem(1'b1, 16'h8002, 16'hCAFE); t0 = cyc;
    repeat (2) @(negedge clk);
    chk("abort_in_pulse_we_n", bus.sram_we_n, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_we_n", bus.sram_we_n, 1);
    chk("abort_ce_n", bus.sram_ce_n, 1);
    chk("abort_doe", bus.sram_doe, 0);
    chk("abort_no_ready", bus.mem_ready, 0);
    chk("abort_mem_rdata", bus.mem_rdata, 0);
    chk("abort_if_rdata", bus.if_rdata, 0);
    mem_last = 16'h0;
    mem_q[0] = '{we: 1'b1, rdata: 16'h0};
    rst = 1'b0; t0 = cyc;
    check_window("restart_wr", 1'b1, 1'b1, 16'h8002, t0);
    repeat (2) @(negedge clk);
    issue_mem(1'b0, 16'h8002, 16'h0); t0 = cyc;
    check_window("restart_rd", 1'b1, 1'b0, 16'h8002, t0);
    repeat (2) @(negedge clk);

    // continuous IF, three reads with changing data
    din_ovr = 1'b1; din_val = 16'h0001;
    issue_if(16'h0030, 16'h0001); t0 = cyc;
    for (int k = 0; k < 3; k++) begin
      wait_ready(1'b0, 40, lat);
      rdy[k] = (lat < 0) ? -1000 : cyc;
      if (k < 2) begin
        din_val = 16'(k + 2);
        if_q.push_back('{we: 1'b0, rdata: 16'(k + 2)});
      end
    end
    bus.if_req = 1'b0; din_ovr = 1'b0;
    chk("stream_first", rdy[0] - t0, W + 1);
    chk("stream_gap1", rdy[1] - rdy[0], W + 2);
    chk("stream_gap2", rdy[2] - rdy[1], W + 2);
    repeat (3) @(negedge clk);
    if_q.delete();

    // randomized concurrent traffic
    fork
      begin
        int l;
        logic [15:0] a;
        for (int n = 0; n < 30; n++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          a = 16'($urandom_range(0, 255));
          issue_if(a, ref_mem[idx(a)]);
          wait_ready(1'b0, 400, l);
          chk("rand_if_done", int'(l >= 0), 1);
          bus.if_req = 1'b0;
        end
      end
      begin
        int l;
        logic [15:0] a;
        for (int n = 0; n < 30; n++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          a = 16'h8000 | 16'($urandom_range(0, 15));
          issue_mem(1'($urandom_range(0, 1)), a, 16'($urandom));
          wait_ready(1'b1, 400, l);
          chk("rand_mem_done", int'(l >= 0), 1);
          bus.mem_req = 1'b0;
        end
      end
    join
    repeat (5) @(negedge clk);
    chk("if_q_drained", if_q.size(), 0);
    chk("mem_q_drained", mem_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
Shares the single on-board SRAM between instruction fetch (IF) and the data-memory stage (MEM) of the 16-bit pipeline.
- Arbitrates the two requesters and sequences multi-cycle SRAM read/write timing with a state machine.
- Returns read data and a one-cycle ready pulse to the granted port.
- Drives per-port stall requests into the pipeline stall controller, so a structural conflict stalls IF (or MEM) cleanly.

Parameters:
WAIT_CYCLES, 2, read access / write-pulse length in clk cycles; legal range 1..15
SRAM_AW, 18, SRAM address width; upper SRAM_AW-16 bits driven to zero

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high; asserted level equals `RstEnable
if_req  in  1  IF read request, held until if_ready
if_addr  in  16  IF word address
if_rdata  out  16  IF read data, registered
if_ready  out  1  one-cycle completion pulse for IF
if_stall_o  out  1  if_req & ~if_ready
mem_req  in  1  MEM access request, held until mem_ready
mem_we  in  1  1 = write, 0 = read
mem_addr  in  16  MEM word address
mem_wdata  in  16  MEM write data
mem_rdata  out  16  MEM read data, registered
mem_ready  out  1  one-cycle completion pulse for MEM
mem_stall_o  out  1  mem_req & ~mem_ready
sram_addr  out  SRAM_AW  SRAM address, registered
sram_dout  out  16  SRAM write data, registered
sram_doe  out  1  1 = drive SRAM data pins (external tristate)
sram_din  in  16  SRAM data pins as seen by the block
sram_ce_n  out  1  chip enable, active-low
sram_oe_n  out  1  output enable, active-low
sram_we_n  out  1  write enable, active-low

Behaviour:
- Reset is synchronous, active-high, and has priority over everything, including mid-access. After the next clk edge:
  - state = IDLE; wait counter = 0
  - sram_ce_n, sram_oe_n, sram_we_n = 1; sram_doe = 0
  - sram_addr, sram_dout = 0
  - if_rdata, mem_rdata = 0; ready pulses = 0
- A partially performed write aborted by reset is not completed, and the requester gets no ready.
- States: IDLE, READ, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- IDLE:
  - If any req is high, pick the grant, latch the port id, address, we and wdata, and assert sram_ce_n = 0.
  - Read: sram_oe_n = 0, go to READ.
  - Write: sram_doe = 1, go to WR_SETUP.
  - IF is always a read.
- Grant: MEM has fixed priority over IF. The grant is held until DONE; requests arriving mid-access are not sampled.
- READ: stays WAIT_CYCLES cycles. On the last cycle's edge, capture sram_din into the granted port's rdata, raise oe_n/ce_n, and go to DONE.
- WR_SETUP: 1 cycle, we_n = 1. WR_PULSE: WAIT_CYCLES cycles, we_n = 0. WR_HOLD: 1 cycle, we_n = 1, doe still 1. Then go to DONE with doe = 0 and ce_n = 1.
- DONE: 1 cycle; the granted port's ready = 1, the other port's ready = 0. Go to IDLE. Requests are not sampled in DONE, which gives a one-cycle bus turnaround.
- Latency from the sampling edge to the ready cycle:
  - read: WAIT_CYCLES + 1
  - write: WAIT_CYCLES + 3
- Minimum back-to-back period is latency + 1.
- rdata holds until the next read completes on that port. Writes never change rdata.
- Simultaneous if_req and mem_req in IDLE: MEM is served first. IF stays stalled (if_stall_o = 1) and is granted at the next IDLE.
- A requester that drops req mid-access is not cancelled: the access completes and ready pulses anyway.
- The wait counter is 4 bits, loaded with WAIT_CYCLES-1 and decremented to 0. It never wraps.

Optional Feature:
ARB_RR_EN
- Defined: round-robin grant. A 1-bit last_grant register (reset = IF) makes the port not served last win on simultaneous requests. A lone request is always granted.
- Undefined: fixed MEM priority as above; no last_grant register exists.

Decomposition:
- Shared defines.v gets:
  - state encodings (`ARB_IDLE .. `ARB_DONE, 3 bits)
  - port ids `ARB_PORT_IF / `ARB_PORT_MEM
  - SRAM width macros
  - existing `RstEnable, `StallYes/`StallNo, `WriteEnable
- No sub-module: the FSM, counter and grant logic form a single module.

Test Plan:
- WAIT_CYCLES=2; if_req, if_addr=0x0040, sram_din=0x1234 -> sram_addr=0x00040 with oe_n=0 for 2 cycles; if_ready pulses exactly at cycle 3 after sampling; if_rdata=0x1234; if_stall_o=1 until then.
- mem_req, mem_we=1, mem_addr=0x8000, mem_wdata=0xBEEF -> doe=1 for 4 cycles; we_n low exactly 2 cycles, framed by 1 setup and 1 hold cycle; mem_ready at cycle 5; mem_rdata unchanged.
- if_req and mem_req (read, 0x0010) rise on the same cycle -> MEM is served first; IF starts the cycle after MEM's DONE; IF's ready arrives 4 cycles after mem_ready. With ARB_RR_EN and last_grant=MEM, IF is served first.
- rst asserted during WR_PULSE -> next edge: we_n=1, ce_n=1, doe=0, state IDLE, no mem_ready pulse; a request held after rst deasserts restarts the full write.
- Continuous if_req across 3 reads with sram_din changing 0x0001/0x0002/0x0003 -> if_ready every 4 cycles; the captured values are correct and in order.
